// File: rtl/lfsr_rnd_arb.sv
// ---------------------------------------------------------------------------
// lfsr_rnd_arb
// Shares one 64-bit XNOR LFSR among NREQ requesters. A round-robin arbiter
// hands out at most one grant per cycle; each grant carries the low OUT_W
// bits of the LFSR as it stood in the arbitration cycle. The block also
// sequences a two-word seed load and a warm-up period in which the LFSR
// runs but no grants are issued.
// ---------------------------------------------------------------------------
module lfsr_rnd_arb #(
    parameter int NREQ   = 4,   // number of requesters, 1..16
    parameter int OUT_W  = 3,   // random value width, 1..64
    parameter int WARMUP = 16   // blocked LFSR steps after reset/seed, 0 = none
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic [NREQ-1:0]  req_i,
    output logic [NREQ-1:0]  gnt_o,
    output logic [OUT_W-1:0] rnd_o,
    output logic             rnd_vld_o,
    input  logic             seed_wr_i,
    input  logic [31:0]      seed_data_i,
    output logic             busy_o
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    // Wide enough to hold WARMUP itself; WARMUP==0 still gets a 1-bit counter.
    localparam int CNT_W = $clog2(WARMUP + 2);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SEED_HI = 2'd1,
        ST_WARM    = 2'd2
    } state_e;

    // State entered after reset and after a completed seed load.
    localparam state_e           POST_SEED_STATE = (WARMUP == 0) ? ST_RUN : ST_WARM;
    localparam logic [CNT_W-1:0] CNT_INIT        = CNT_W'(WARMUP);

    // One XNOR LFSR step; the all-zero state is legal and steps to ...01.
    function automatic logic [63:0] lfsr_step(input logic [63:0] v);
        return {v[62:0], ~(v[63] ^ v[62] ^ v[60] ^ v[59])};
    endfunction

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q,   cnt_d;
    logic [63:0]          lfsr_q,  lfsr_d;
    logic [PTR_W-1:0]     ptr_q,   ptr_d;
    logic [NREQ-1:0]      gnt_q,   gnt_d;
    logic [OUT_W-1:0]     rnd_q,   rnd_d;

    logic                 arb_en;     // arbitration allowed this cycle
    logic [NREQ-1:0]      eligible;
    logic                 win_vld;
    logic [PTR_W-1:0]     win_idx;

    // -----------------------------------------------------------------------
    // Control FSM: seeding, warm-up and LFSR advance.
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lfsr_d  = lfsr_q;
        arb_en  = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                if (seed_wr_i) begin
                    lfsr_d  = {lfsr_q[63:32], seed_data_i};
                    state_d = ST_SEED_HI;
                end else begin
                    lfsr_d = lfsr_step(lfsr_q);
                    arb_en = 1'b1;
                end
            end

            ST_SEED_HI: begin
                // LFSR holds here until the upper word arrives.
                if (seed_wr_i) begin
                    lfsr_d  = {seed_data_i, lfsr_q[31:0]};
                    state_d = POST_SEED_STATE;
                    cnt_d   = CNT_INIT;
                end
            end

            ST_WARM: begin
                if (seed_wr_i) begin
                    // A new seed restarts the whole load sequence.
                    lfsr_d  = {lfsr_q[63:32], seed_data_i};
                    state_d = ST_SEED_HI;
                end else begin
                    lfsr_d = lfsr_step(lfsr_q);
                    // Count value 1 marks the last of the WARMUP busy cycles.
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end

            default: begin
                state_d = POST_SEED_STATE;
                cnt_d   = CNT_INIT;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Round-robin pick: first eligible requester at or above ptr, wrapping.
    // The requester whose grant is on the output this cycle is masked so a
    // held request cannot be granted twice in a row.
    // -----------------------------------------------------------------------
    assign eligible = req_i & ~gnt_q;

    // Scan eligible requesters starting at the rotating pointer.
    always_comb begin
        int unsigned      sum;
        logic [PTR_W-1:0] idx;
        win_vld = 1'b0;
        win_idx = '0;
        sum     = 0;
        idx     = '0;
        for (int i = 0; i < NREQ; i++) begin
            sum = int'(ptr_q) + i;
            if (sum >= NREQ) begin
                sum = sum - NREQ;
            end
            idx = PTR_W'(sum);
            if (!win_vld && eligible[idx]) begin
                win_vld = 1'b1;
                win_idx = idx;
            end
        end
    end

    // Next grant, random value and pointer; grant is a one-cycle pulse,
    // the random value holds when nothing is granted.
    always_comb begin
        gnt_d = '0;
        rnd_d = rnd_q;
        ptr_d = ptr_q;
        if (arb_en && win_vld) begin
            gnt_d[win_idx] = 1'b1;
            rnd_d          = lfsr_q[OUT_W-1:0];
            if (int'(win_idx) == NREQ - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = win_idx + PTR_W'(1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // State registers. The LFSR is ordinary datapath state, so it is reset
    // to zero like everything else and any pending grant is dropped.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q <= POST_SEED_STATE;
            cnt_q   <= CNT_INIT;
            lfsr_q  <= '0;
            ptr_q   <= '0;
            gnt_q   <= '0;
            rnd_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            rnd_q   <= rnd_d;
        end
    end

    assign gnt_o     = gnt_q;
    assign rnd_o     = rnd_q;
    assign rnd_vld_o = |gnt_q;
    assign busy_o    = (state_q != ST_RUN);

endmodule

// File: tb/tb_lfsr_rnd_arb.sv
// ---------------------------------------------------------------------------
// tb_lfsr_rnd_arb
// Two instances: dut_a with a 16-cycle warm-up, dut_b with warm-up disabled.
// Each test drives stimulus, pushes the expected next-cycle output onto a
// scoreboard queue and pops/compares it one clock later.
// ---------------------------------------------------------------------------
module tb_lfsr_rnd_arb;

    typedef struct packed {
        logic [3:0] gnt;
        logic [2:0] rnd;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a_l = 1'b1;
    logic [3:0]  req_a = '0;
    logic        seed_wr_a = 1'b0;
    logic [31:0] seed_data_a = '0;
    logic [3:0]  gnt_a;
    logic [2:0]  rnd_a;
    logic        vld_a;
    logic        busy_a;

    logic        rst_b_l = 1'b1;
    logic [3:0]  req_b = '0;
    logic        seed_wr_b = 1'b0;
    logic [31:0] seed_data_b = '0;
    logic [3:0]  gnt_b;
    logic [2:0]  rnd_b;
    logic        vld_b;
    logic        busy_b;

    lfsr_rnd_arb #(.NREQ(4), .OUT_W(3), .WARMUP(16)) dut_a (
        .clk        (clk),
        .rst_l      (rst_a_l),
        .req_i      (req_a),
        .gnt_o      (gnt_a),
        .rnd_o      (rnd_a),
        .rnd_vld_o  (vld_a),
        .seed_wr_i  (seed_wr_a),
        .seed_data_i(seed_data_a),
        .busy_o     (busy_a)
    );

    lfsr_rnd_arb #(.NREQ(4), .OUT_W(3), .WARMUP(0)) dut_b (
        .clk        (clk),
        .rst_l      (rst_b_l),
        .req_i      (req_b),
        .gnt_o      (gnt_b),
        .rnd_o      (rnd_b),
        .rnd_vld_o  (vld_b),
        .seed_wr_i  (seed_wr_b),
        .seed_data_i(seed_data_b),
        .busy_o     (busy_b)
    );

    int          checks = 0;
    int          errors = 0;
    exp_t        sb_q[$];
    exp_t        e;
    logic [63:0] m_lfsr;     // reference LFSR value in the current cycle
    logic [2:0]  last_rnd;   // reference value rnd_o holds between grants

    function automatic logic [63:0] lfsr_next(input logic [63:0] v);
        logic fb;
        fb = ~(v[63] ^ v[62] ^ v[60] ^ v[59]);
        return (v << 1) | {63'd0, fb};
    endfunction

    // Queue the expected output for the cycle after the current one.
    task automatic push_exp(input logic [3:0] gnt);
        exp_t x;
        if (gnt != 4'b0000) begin
            last_rnd = m_lfsr[2:0];
        end
        x.gnt = gnt;
        x.rnd = last_rnd;
        sb_q.push_back(x);
    endtask

    // One clock; the reference LFSR advances unless the DUT is loading a seed.
    task automatic tick(input bit adv);
        @(posedge clk);
        #1;
        if (adv) begin
            m_lfsr = lfsr_next(m_lfsr);
        end
    endtask

    // Reset dut_a and wait (bounded) for warm-up to finish.
    task automatic reset_a();
        int n;
        req_a       = '0;
        seed_wr_a   = 1'b0;
        seed_data_a = '0;
        rst_a_l     = 1'b0;
        sb_q.delete();
        last_rnd    = '0;
        @(negedge clk);
        rst_a_l = 1'b1;
        m_lfsr  = '0;
        n       = 0;
        while (busy_a === 1'b1 && n < 40) begin
            tick(1'b1);
            n++;
        end
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL warmup_len: busy cycles=%0d, want 16", n);
        end
    endtask

    task automatic test_reset();
        rst_a_l = 1'b0;
        rst_b_l = 1'b0;
        #1;
        checks++;
        if (gnt_a !== 4'b0000 || rnd_a !== 3'd0 || vld_a !== 1'b0 || busy_a !== 1'b1) begin
            errors++;
            $display("FAIL reset_a: gnt=%b rnd=%0d vld=%b busy=%b, want 0000 0 0 1",
                     gnt_a, rnd_a, vld_a, busy_a);
        end
        checks++;
        if (gnt_b !== 4'b0000 || rnd_b !== 3'd0 || vld_b !== 1'b0 || busy_b !== 1'b0) begin
            errors++;
            $display("FAIL reset_b: gnt=%b rnd=%0d vld=%b busy=%b, want 0000 0 0 0",
                     gnt_b, rnd_b, vld_b, busy_b);
        end
    endtask

    // Warm-up then a single uncontended request on the first RUN cycle.
    task automatic test_warmup();
        logic [3:0] reqs [2];
        logic [3:0] gnts [2];
        reqs = '{4'b0001, 4'b0000};
        gnts = '{4'b0001, 4'b0000};
        reset_a();
        for (int i = 0; i < 2; i++) begin
            req_a = reqs[i];
            push_exp(gnts[i]);
            tick(1'b1);
            e = sb_q.pop_front();
            checks++;
            if (gnt_a !== e.gnt || rnd_a !== e.rnd || vld_a !== (|e.gnt)) begin
                errors++;
                $display("FAIL warm_grant[%0d]: got gnt=%b rnd=%0d vld=%b, want gnt=%b rnd=%0d",
                         i, gnt_a, rnd_a, vld_a, e.gnt, e.rnd);
            end
        end
    endtask

    // WARMUP=0 instance: seed 0x5 and hold one request; masking alternates.
    task automatic test_seed_nowarm();
        req_b = '0;
        seed_wr_b = 1'b0;
        rst_b_l = 1'b0;
        @(negedge clk);
        rst_b_l = 1'b1;
        #1;
        checks++;
        if (busy_b !== 1'b0) begin
            errors++;
            $display("FAIL nowarm_busy_after_reset: busy=%b, want 0", busy_b);
        end
        sb_q.delete();
        last_rnd    = '0;
        seed_wr_b   = 1'b1;
        seed_data_b = 32'h0000_0005;
        tick(1'b0);
        checks++;
        if (busy_b !== 1'b1) begin
            errors++;
            $display("FAIL nowarm_busy_seed_hi: busy=%b, want 1", busy_b);
        end
        seed_data_b = 32'h0000_0000;
        tick(1'b0);
        seed_wr_b = 1'b0;
        m_lfsr    = 64'h5;
        checks++;
        if (busy_b !== 1'b0) begin
            errors++;
            $display("FAIL nowarm_busy_after_seed: busy=%b, want 0", busy_b);
        end
        req_b = 4'b0001;
        for (int i = 0; i < 6; i++) begin
            push_exp((i % 2 == 0) ? 4'b0001 : 4'b0000);
            tick(1'b1);
            e = sb_q.pop_front();
            checks++;
            if (gnt_b !== e.gnt || rnd_b !== e.rnd || vld_b !== (|e.gnt)) begin
                errors++;
                $display("FAIL nowarm_grant[%0d]: got gnt=%b rnd=%0d vld=%b, want gnt=%b rnd=%0d",
                         i, gnt_b, rnd_b, vld_b, e.gnt, e.rnd);
            end
        end
        req_b   = '0;
        rst_b_l = 1'b0;
    endtask

    // All four requesting continuously: one grant per cycle, rotating.
    task automatic test_back_to_back();
        logic [3:0] gnts [9];
        gnts = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
        reset_a();
        for (int i = 0; i < 9; i++) begin
            req_a = (i < 8) ? 4'b1111 : 4'b0000;
            push_exp(gnts[i]);
            tick(1'b1);
            e = sb_q.pop_front();
            checks++;
            if (gnt_a !== e.gnt || rnd_a !== e.rnd || vld_a !== (|e.gnt)) begin
                errors++;
                $display("FAIL b2b[%0d]: got gnt=%b rnd=%0d vld=%b, want gnt=%b rnd=%0d",
                         i, gnt_a, rnd_a, vld_a, e.gnt, e.rnd);
            end
        end
    endtask

    // Sparse requests: pointer skips idle requesters and wraps past 3.
    task automatic test_wrap();
        logic [3:0] reqs [4];
        logic [3:0] gnts [4];
        reqs = '{4'b0101, 4'b0101, 4'b0001, 4'b0000};
        gnts = '{4'b0001, 4'b0100, 4'b0001, 4'b0000};
        reset_a();
        for (int i = 0; i < 4; i++) begin
            req_a = reqs[i];
            push_exp(gnts[i]);
            tick(1'b1);
            e = sb_q.pop_front();
            checks++;
            if (gnt_a !== e.gnt || rnd_a !== e.rnd || vld_a !== (|e.gnt)) begin
                errors++;
                $display("FAIL wrap[%0d]: got gnt=%b rnd=%0d vld=%b, want gnt=%b rnd=%0d",
                         i, gnt_a, rnd_a, vld_a, e.gnt, e.rnd);
            end
        end
    endtask

    // Seed write collides with a request: request ignored until warm-up ends.
    task automatic test_seed_block();
        int          n;
        logic [31:0] lo;
        logic [31:0] hi;
        lo = 32'hA5C3_1E69;
        hi = 32'h0F1E_2D3C;
        reset_a();
        req_a       = 4'b0010;
        seed_wr_a   = 1'b1;
        seed_data_a = lo;
        push_exp(4'b0000);
        tick(1'b0);
        e = sb_q.pop_front();
        checks++;
        if (gnt_a !== e.gnt || rnd_a !== e.rnd || busy_a !== 1'b1) begin
            errors++;
            $display("FAIL seed_lo: got gnt=%b rnd=%0d busy=%b, want gnt=%b rnd=%0d busy=1",
                     gnt_a, rnd_a, busy_a, e.gnt, e.rnd);
        end
        seed_data_a = hi;
        push_exp(4'b0000);
        tick(1'b0);
        seed_wr_a = 1'b0;
        m_lfsr    = {hi, lo};
        e = sb_q.pop_front();
        checks++;
        if (gnt_a !== e.gnt || rnd_a !== e.rnd || busy_a !== 1'b1) begin
            errors++;
            $display("FAIL seed_hi: got gnt=%b rnd=%0d busy=%b, want gnt=%b rnd=%0d busy=1",
                     gnt_a, rnd_a, busy_a, e.gnt, e.rnd);
        end
        n = 0;
        while (busy_a === 1'b1 && n < 40) begin
            push_exp(4'b0000);
            tick(1'b1);
            n++;
            e = sb_q.pop_front();
            checks++;
            if (gnt_a !== e.gnt || rnd_a !== e.rnd) begin
                errors++;
                $display("FAIL seed_warm[%0d]: got gnt=%b rnd=%0d, want gnt=%b rnd=%0d",
                         n, gnt_a, rnd_a, e.gnt, e.rnd);
            end
        end
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL seed_warm_len: busy cycles=%0d, want 16", n);
        end
        for (int i = 0; i < 2; i++) begin
            push_exp((i == 0) ? 4'b0010 : 4'b0000);
            tick(1'b1);
            e = sb_q.pop_front();
            checks++;
            if (gnt_a !== e.gnt || rnd_a !== e.rnd || vld_a !== (|e.gnt)) begin
                errors++;
                $display("FAIL seed_grant[%0d]: got gnt=%b rnd=%0d vld=%b, want gnt=%b rnd=%0d",
                         i, gnt_a, rnd_a, vld_a, e.gnt, e.rnd);
            end
        end
        req_a = '0;
    endtask

    // Async reset with a grant on the output, then again mid warm-up.
    task automatic test_reset_mid();
        logic [3:0] gnts [2];
        gnts = '{4'b0001, 4'b0010};
        reset_a();
        req_a = 4'b0001;
        tick(1'b1);
        checks++;
        if (gnt_a !== 4'b0001) begin
            errors++;
            $display("FAIL mid_pre_gnt: gnt=%b, want 0001", gnt_a);
        end
        #2;
        rst_a_l = 1'b0;
        req_a   = '0;
        #1;
        checks++;
        if (gnt_a !== 4'b0000 || rnd_a !== 3'd0 || vld_a !== 1'b0 || busy_a !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_run: gnt=%b rnd=%0d vld=%b busy=%b, want 0000 0 0 1",
                     gnt_a, rnd_a, vld_a, busy_a);
        end
        @(negedge clk);
        rst_a_l = 1'b1;
        repeat (11) @(posedge clk);
        #3;
        rst_a_l = 1'b0;
        #1;
        checks++;
        if (gnt_a !== 4'b0000 || vld_a !== 1'b0 || busy_a !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_warm: gnt=%b vld=%b busy=%b, want 0000 0 1",
                     gnt_a, vld_a, busy_a);
        end
        reset_a();
        req_a = 4'b1111;
        for (int i = 0; i < 2; i++) begin
            push_exp(gnts[i]);
            tick(1'b1);
            e = sb_q.pop_front();
            checks++;
            if (gnt_a !== e.gnt || rnd_a !== e.rnd || vld_a !== (|e.gnt)) begin
                errors++;
                $display("FAIL mid_after[%0d]: got gnt=%b rnd=%0d vld=%b, want gnt=%b rnd=%0d",
                         i, gnt_a, rnd_a, vld_a, e.gnt, e.rnd);
            end
        end
        req_a = '0;
    endtask

    initial begin
        m_lfsr   = '0;
        last_rnd = '0;
        test_reset();
        test_warmup();
        test_seed_nowarm();
        test_back_to_back();
        test_wrap();
        test_seed_block();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
